ifetch_prefetch: RTL and testbench

//  Instruction-fetch front end between instruction memory and the core fetch port. Takes the core PC
//  (o_pcOut) and returns i_instr/i_ifValid in the same cycle from a small sequential prefetch FIFO of
//  {addr,instr} entries. Refills over a req/gnt/rvalid bus with one outstanding request.

---
 rtl/ifetch_prefetch.sv | 221 ++++++++++++++++++++++
 tb/tb_ifetch_prefetch.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch.sv
// ---------------------------------------------------------------------------
// ifetch_prefetch
//
// Instruction-fetch front end sitting between instruction memory and the core
// fetch port. A small FIFO holds sequential {address, instruction} pairs that
// were fetched ahead of the core. The core PC is looked up combinationally
// against the two oldest entries, so a hit returns the instruction in the same
// cycle. The FIFO is refilled over a req/gnt/rvalid bus that allows only one
// request in flight. A PC that misses and is not already being fetched is
// treated as a redirect: the FIFO is flushed and fetching restarts at that PC.
//
// Ports
//   i_clk         clock, all state changes on the rising edge
//   i_rst         synchronous, active-low reset
//   i_pc          core program counter to look up
//   o_instr       instruction for i_pc (zero when not valid)
//   o_ifValid     o_instr holds the instruction for i_pc this cycle
//   o_imemReq     bus request, registered, held until granted
//   o_imemAddr    bus word address, registered, bits [1:0] always zero
//   i_imemGnt     request accepted this cycle
//   i_imemRvalid  response data valid this cycle
//   i_imemRdata   response instruction word
// ---------------------------------------------------------------------------
module ifetch_prefetch #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 2,
   parameter logic [XLEN-1:0] PC_START = '0
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [XLEN-1:0] i_pc,
   output logic [31:0]     o_instr,
   output logic            o_ifValid,
   output logic            o_imemReq,
   output logic [XLEN-1:0] o_imemAddr,
   input  logic            i_imemGnt,
   input  logic            i_imemRvalid,
   input  logic [31:0]     i_imemRdata
);

   localparam int WW = XLEN - 2;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetchStateT;

   fetchStateT    state;
   fetchStateT    stateNext;

   logic [WW-1:0] pcWord;
   logic [WW-1:0] busWord;
   logic [WW-1:0] fetchWord;
   logic [WW-1:0] fetchWordNext;
   logic [CW-1:0] count;
   logic [CW-1:0] countBase;
   logic [CW-1:0] countNext;
   logic          drop;
   logic          dropNext;
   logic          hit0;
   logic          hit1;
   logic          pop;
   logic          miss;
   logic          pending;
   logic          redirect;
   logic          rspValid;
   logic          accept;
   logic          spaceNext;
   logic          issue;
   logic          unusedPcBits;

   logic [WW-1:0] entryWord [DEPTH];
   logic [WW-1:0] nextWord  [DEPTH];
   logic [31:0]   entryData [DEPTH];
   logic [31:0]   nextData  [DEPTH];

   // Everything works on word addresses, so +1 on a word address is the
   // +4 byte step and wraps naturally at the top of the address space.
   assign pcWord       = i_pc[XLEN-1:2];
   assign busWord      = o_imemAddr[XLEN-1:2];
   assign unusedPcBits = &{1'b0, i_pc[1:0]};

   // Classify the current PC: hit on the head, hit on the second entry
   // (which retires the head), a miss on an address already being fetched
   // (just flush and wait for it), or a redirect to somewhere new. Also works
   // out how the FIFO occupancy and the fetch pointer move this cycle.
   always_comb begin
      hit0          = (count != '0) && (entryWord[0] == pcWord);
      hit1          = (count >= CW'(2)) && (entryWord[1] == pcWord);
      pop           = hit1 && !hit0;
      miss          = !(hit0 || hit1);
      pending       = miss && (((state != IDLE) && !drop && (busWord == pcWord)) ||
                               ((state == IDLE) && (fetchWord == pcWord)));
      redirect      = miss && !pending;
      rspValid      = (state == WAIT) && i_imemRvalid;
      accept        = rspValid && !drop && !redirect;
      countBase     = miss ? '0 : (pop ? count - CW'(1) : count);
      countNext     = countBase + CW'(accept);
      spaceNext     = countNext < CW'(DEPTH);
      fetchWordNext = redirect ? pcWord : fetchWord;
   end

   // The drop flag marks the one response still owed by the bus as stale.
   // A response that lands in the same cycle as the redirect is already
   // discarded directly, so the flag is only armed when that response is
   // still to come; otherwise it would throw away the refetch of the target.
   always_comb begin
      dropNext = drop;
      if (rspValid) begin
         dropNext = 1'b0;
      end
      if (redirect && ((state == REQ) || ((state == WAIT) && !i_imemRvalid))) begin
         dropNext = 1'b1;
      end
   end

   // Bus state register.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Bus sequencing. A new request is only launched when the FIFO will
   // still have room for its response, so a response can always be pushed.
   always_comb begin
      stateNext = state;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (spaceNext) begin
               stateNext = REQ;
               issue     = 1'b1;
            end
         end
         REQ: begin
            if (i_imemGnt) begin
               stateNext = WAIT;
            end
         end
         WAIT: begin
            if (i_imemRvalid) begin
               if (spaceNext) begin
                  stateNext = REQ;
                  issue     = 1'b1;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Core-facing outputs come straight from the hit compare so a hit is
   // returned in the same cycle the PC is presented.
   always_comb begin
      o_ifValid = hit0 || hit1;
      if (hit0) begin
         o_instr = entryData[0];
      end else if (hit1) begin
         o_instr = entryData[1];
      end else begin
         o_instr = 32'h0;
      end
   end

   // Control registers and the bus request. The request address only moves
   // when a new request is launched, so it stays stable until granted even
   // if the core redirects in the meantime.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         count      <= '0;
         drop       <= 1'b0;
         fetchWord  <= PC_START[XLEN-1:2];
         o_imemReq  <= 1'b0;
         o_imemAddr <= '0;
      end else begin
         count     <= countNext;
         drop      <= dropNext;
         o_imemReq <= (stateNext == REQ);
         if (issue) begin
            o_imemAddr <= {fetchWordNext, 2'b00};
            fetchWord  <= fetchWordNext + WW'(1);
         end else begin
            fetchWord  <= fetchWordNext;
         end
      end
   end

   // FIFO payload: shift down on a pop, then write the response at the
   // first free slot after that shift (or after a flush, at slot 0).
   always_comb begin
      nextWord = entryWord;
      nextData = entryData;
      if (pop) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            nextWord[i] = entryWord[i+1];
            nextData[i] = entryData[i+1];
         end
      end
      if (accept) begin
         nextWord[countBase[AW-1:0]] = busWord;
         nextData[countBase[AW-1:0]] = i_imemRdata;
      end
   end

   // Payload storage needs no reset; entries beyond count are never looked at.
   always_ff @(posedge i_clk) begin
      entryWord <= nextWord;
      entryData <= nextData;
   end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch_prefetch
//
// Directed bench for ifetch_prefetch. A transaction-level model (a queue of
// prefetched instructions plus a record of the single outstanding bus
// transaction) predicts the core and bus outputs every cycle, and a small
// memory responder driven from that model answers the bus. Directed
// sequences cover reset, sequential fetch, redirects, address wrap, reset
// during a request and a stalled core, with hand-computed values pinned.
// ---------------------------------------------------------------------------
module tb_ifetch_prefetch;

   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] PC_START = 32'h0;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [31:0] i_pc;
   logic [31:0] o_instr;
   logic        o_ifValid;
   logic        o_imemReq;
   logic [31:0] o_imemAddr;
   logic        i_imemGnt;
   logic        i_imemRvalid;
   logic [31:0] i_imemRdata;

   ifetch_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .PC_START(PC_START)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_pc         (i_pc),
      .o_instr      (o_instr),
      .o_ifValid    (o_ifValid),
      .o_imemReq    (o_imemReq),
      .o_imemAddr   (o_imemAddr),
      .i_imemGnt    (i_imemGnt),
      .i_imemRvalid (i_imemRvalid),
      .i_imemRdata  (i_imemRdata)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } entryT;

   int          errors = 0;
   int          checks = 0;

   // Model: prefetched instructions, the next address to fetch, and the
   // single bus transaction (requested-not-granted or granted-awaiting-data).
   entryT       fifoQ[$];
   logic [31:0] nextFetch   = 32'h0;
   logic [31:0] busAddr     = 32'h0;
   bit          reqOut      = 1'b0;
   bit          awaitData   = 1'b0;
   bit          discardNext = 1'b0;
   bit          modelLive   = 1'b0;

   // Responder controls.
   int          reqAge   = 0;
   int          waitAge  = 0;
   int          gntDelay = 0;
   int          rspWait  = 0;
   bit          holdGnt  = 1'b0;
   bit          strayRv  = 1'b0;

   // Stimulus and per-cycle predictions.
   logic [31:0] pcStim   = 32'h0;
   logic        rstStim  = 1'b0;
   bit          expValid = 1'b0;
   logic [31:0] expInstr = 32'h0;
   bit          curReq   = 1'b0;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return 32'hC0DE_0000 | {16'h0, a[15:0]};
   endfunction

   function automatic int hitIndex(input logic [31:0] pc);
      for (int k = 0; k < fifoQ.size() && k < 2; k++) begin
         if (fifoQ[k].addr[31:2] == pc[31:2]) return k;
      end
      return -1;
   endfunction

   task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus();
      i_rst        = rstStim;
      i_pc         = pcStim;
      i_imemGnt    = modelLive && reqOut && !holdGnt && (reqAge >= gntDelay);
      i_imemRvalid = (modelLive && awaitData && (waitAge >= rspWait)) || strayRv;
      i_imemRdata  = awaitData ? memWord(busAddr) : 32'hDEAD_BEEF;
   endtask

   task automatic checkOutput();
      int k;
      k        = hitIndex(i_pc);
      expValid = (k >= 0);
      expInstr = 32'h0;
      if (k >= 0) expInstr = fifoQ[k].data;
      curReq   = reqOut;
      if (modelLive) begin
         checkEq("ifValid",  32'(o_ifValid), 32'(expValid));
         checkEq("instr",    o_instr,        expInstr);
         checkEq("imemReq",  32'(o_imemReq), 32'(reqOut));
         checkEq("imemAddr", o_imemAddr,     busAddr);
      end
   endtask

   // Advance the model by one clock using the inputs driven this cycle.
   task automatic modelStep();
      int   k;
      bit   busy;
      bit   pend;
      bit   redirect;
      bit   respDone;
      bit   oldDiscard;
      if (!i_rst) begin
         fifoQ.delete();
         nextFetch   = PC_START;
         busAddr     = 32'h0;
         reqOut      = 1'b0;
         awaitData   = 1'b0;
         discardNext = 1'b0;
         reqAge      = 0;
         waitAge     = 0;
         modelLive   = 1'b1;
         return;
      end
      if (!modelLive) return;
      k        = hitIndex(i_pc);
      busy     = reqOut || awaitData;
      redirect = 1'b0;
      respDone = awaitData && i_imemRvalid;
      if (k == 1) begin
         void'(fifoQ.pop_front());
      end else if (k < 0) begin
         pend = (busy && !discardNext && busAddr[31:2] == i_pc[31:2]) ||
                (!busy && nextFetch[31:2] == i_pc[31:2]);
         fifoQ.delete();
         if (!pend) begin
            redirect  = 1'b1;
            nextFetch = {i_pc[31:2], 2'b00};
         end
      end
      oldDiscard = discardNext;
      if (respDone) begin
         if (!oldDiscard && !redirect) fifoQ.push_back('{addr: busAddr, data: i_imemRdata});
         discardNext = 1'b0;
         awaitData   = 1'b0;
      end
      if (redirect && (reqOut || awaitData)) discardNext = 1'b1;
      if (awaitData) waitAge++;
      if (reqOut && i_imemGnt) begin
         reqOut    = 1'b0;
         awaitData = 1'b1;
         waitAge   = 0;
      end else if (reqOut) begin
         reqAge++;
      end
      if (!reqOut && !awaitData && fifoQ.size() < DEPTH) begin
         busAddr   = nextFetch;
         nextFetch = nextFetch + 32'd4;
         reqOut    = 1'b1;
         reqAge    = 0;
      end
   endtask

   task automatic runCycle();
      @(negedge i_clk);
      applyStimulus();
      #1;
      checkOutput();
      modelStep();
   endtask

   task automatic doReset(input int n);
      rstStim = 1'b0;
      holdGnt = 1'b0;
      strayRv = 1'b0;
      repeat (n) runCycle();
      rstStim = 1'b1;
   endtask

   // Runs until the core sees a valid instruction, then pins its value.
   task automatic waitValid(input string name, input logic [31:0] instr);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         runCycle();
         if (o_ifValid) begin
            found = 1'b1;
            checkEq(name, o_instr, instr);
         end
      end
      checkEq({name, " reached"}, 32'(found), 32'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit seenReq;
      bit seenValid;
      bit found;
      i_rst = 1'b0; i_pc = 32'h0; i_imemGnt = 1'b0; i_imemRvalid = 1'b0; i_imemRdata = 32'h0;

      // Reset release, fill and core stall on a full FIFO.
      $display("[TB] reset release and stalled core");
      gntDelay = 0; rspWait = 0; pcStim = 32'h0;
      doReset(2);
      runCycle(); checkEq("t1 req at release", 32'(o_imemReq), 32'd0);
                  checkEq("t1 valid at release", 32'(o_ifValid), 32'd0);
      runCycle(); checkEq("t1 first req", 32'(o_imemReq), 32'd1);
                  checkEq("t1 first addr", o_imemAddr, 32'h0);
      runCycle(); checkEq("t1 valid in wait", 32'(o_ifValid), 32'd0);
      runCycle(); checkEq("t1 valid", 32'(o_ifValid), 32'd1);
                  checkEq("t1 instr", o_instr, 32'hC0DE_0000);
                  checkEq("t1 prefetch req", 32'(o_imemReq), 32'd1);
                  checkEq("t1 prefetch addr", o_imemAddr, 32'h4);
      runCycle(); checkEq("t1 req dropped", 32'(o_imemReq), 32'd0);
      for (int i = 0; i < 4; i++) begin
         runCycle();
         checkEq("t6 no req when full", 32'(o_imemReq), 32'd0);
         checkEq("t6 valid stall", 32'(o_ifValid), 32'd1);
         checkEq("t6 instr stall", o_instr, 32'hC0DE_0000);
      end

      // Sequential core, zero-wait then slower memory.
      $display("[TB] sequential fetch");
      pcStim = 32'h4;
      for (int i = 0; i < 30; i++) begin
         runCycle();
         if (expValid) pcStim = pcStim + 32'd4;
      end
      gntDelay = 1; rspWait = 2;
      for (int i = 0; i < 30; i++) begin
         runCycle();
         if (expValid) pcStim = pcStim + 32'd4;
      end

      // Redirect to 0x100 while the request for 0x8 waits for data.
      $display("[TB] redirect during wait");
      gntDelay = 0; rspWait = 3; pcStim = 32'h0;
      doReset(2);
      waitValid("t3 instr 0", 32'hC0DE_0000);
      pcStim = 32'h4;
      found  = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         runCycle();
         if (awaitData && busAddr == 32'h8) found = 1'b1;
      end
      checkEq("t3 wait for 0x8", 32'(found), 32'd1);
      pcStim    = 32'h100;
      seenReq   = 1'b0;
      seenValid = 1'b0;
      for (int i = 0; i < 40 && !seenValid; i++) begin
         runCycle();
         if (curReq && !seenReq) begin
            seenReq = 1'b1;
            checkEq("t3 refetch addr", o_imemAddr, 32'h100);
         end
         if (o_ifValid) begin
            seenValid = 1'b1;
            checkEq("t3 target instr", o_instr, 32'hC0DE_0100);
         end
      end
      checkEq("t3 refetch seen", 32'(seenReq), 32'd1);
      checkEq("t3 target seen", 32'(seenValid), 32'd1);

      // Top of the address space wraps to zero.
      $display("[TB] address wrap");
      pcStim    = 32'hFFFF_FFFC;
      seenValid = 1'b0;
      found     = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         runCycle();
         if (!seenValid && o_ifValid) begin
            seenValid = 1'b1;
            checkEq("t4 top instr", o_instr, 32'hC0DE_FFFC);
         end
         if (seenValid && curReq) begin
            found = 1'b1;
            checkEq("t4 wrapped addr", o_imemAddr, 32'h0);
         end
      end
      checkEq("t4 wrap req seen", 32'(found), 32'd1);
      pcStim = 32'h0;
      waitValid("t4 instr at 0", 32'hC0DE_0000);

      // Reset in the middle of an ungranted request, then a stray response.
      $display("[TB] reset during request");
      gntDelay = 0; rspWait = 0; pcStim = 32'h0;
      doReset(2);
      holdGnt = 1'b1;
      runCycle();
      runCycle(); checkEq("t5 req held", 32'(o_imemReq), 32'd1);
      rstStim = 1'b0;
      runCycle();
      rstStim = 1'b1;
      strayRv = 1'b1;
      holdGnt = 1'b0;
      runCycle(); checkEq("t5 req cleared", 32'(o_imemReq), 32'd0);
                  checkEq("t5 valid cleared", 32'(o_ifValid), 32'd0);
      strayRv = 1'b0;
      runCycle(); checkEq("t5 stray ignored", 32'(o_ifValid), 32'd0);
                  checkEq("t5 fresh req", 32'(o_imemReq), 32'd1);
                  checkEq("t5 fresh addr", o_imemAddr, PC_START);
      waitValid("t5 instr", 32'hC0DE_0000);

      // Redirect while a request is still waiting for its grant.
      $display("[TB] redirect during request");
      gntDelay = 2; rspWait = 1; pcStim = 32'h0;
      doReset(2);
      runCycle();
      runCycle();
      pcStim = 32'h40;
      runCycle(); checkEq("t7 req kept", 32'(o_imemReq), 32'd1);
                  checkEq("t7 addr kept", o_imemAddr, 32'h0);
      runCycle(); checkEq("t7 req until gnt", 32'(o_imemReq), 32'd1);
                  checkEq("t7 addr until gnt", o_imemAddr, 32'h0);
      waitValid("t7 target instr", 32'hC0DE_0040);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
